// File: rtl/mdu_responder.sv
// Multiply/divide responder: fixed-latency MULT/DIV into HI/LO, plus MTHI/MTLO.
// Ports: clk, reset (async, active-low), start/op/a/b request; busy, hi, lo out.
module mdu_responder #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  state_t        state;
  logic [CW-1:0] cnt;
  hilo_t         pend;

  logic is_mult;
  logic is_multu;
  logic is_div;
  logic is_divu;
  logic is_mthi;
  logic is_mtlo;

  always_comb begin
    is_mult  = 1'b0;
    is_multu = 1'b0;
    is_div   = 1'b0;
    is_divu  = 1'b0;
    is_mthi  = 1'b0;
    is_mtlo  = 1'b0;
    unique case (1'b1)
      (op == OP_MULT):  is_mult  = 1'b1;
      (op == OP_MULTU): is_multu = 1'b1;
      (op == OP_DIV):   is_div   = 1'b1;
      (op == OP_DIVU):  is_divu  = 1'b1;
      (op == OP_MTHI):  is_mthi  = 1'b1;
      (op == OP_MTLO):  is_mtlo  = 1'b1;
      default: ;
    endcase
  end

  logic [63:0] prod_s;
  logic [63:0] prod_u;

  always_comb begin
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};
  end

  // Signed divide runs on magnitudes; signs are reapplied after.
  logic        sgn;
  logic [31:0] num;
  logic [31:0] den;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_res;
  logic [31:0] r_res;
  logic        neg_q;
  logic        neg_r;

  always_comb begin
    sgn   = is_div;
    num   = (sgn && a[31]) ? (~a + 32'd1) : a;
    den   = (sgn && b[31]) ? (~b + 32'd1) : b;
    q_mag = 32'd0;
    r_mag = 32'd0;
    if (den != 32'd0) begin
      q_mag = num / den;
      r_mag = num % den;
    end
    neg_q = sgn && (a[31] ^ b[31]);
    neg_r = sgn && a[31];
    q_res = neg_q ? (~q_mag + 32'd1) : q_mag;
    r_res = neg_r ? (~r_mag + 32'd1) : r_mag;
  end

  hilo_t res;

  // 8000_0000 / FFFF_FFFF falls out of the magnitude path
  // as q=8000_0000, r=0 with no special case.
  always_comb begin
    res = '0;
    unique case (1'b1)
      is_mult:  res = '{hi: prod_s[63:32], lo: prod_s[31:0]};
      is_multu: res = '{hi: prod_u[63:32], lo: prod_u[31:0]};
      (is_div || is_divu): begin
        if (b == 32'd0) res = '{hi: a, lo: 32'hFFFF_FFFF};
        else            res = '{hi: r_res, lo: q_res};
      end
      default: res = '0;
    endcase
  end

  logic arith;
  assign arith = is_mult | is_multu | is_div | is_divu;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      pend  <= '0;
      busy  <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (arith) begin
              pend  <= res;
              cnt   <= (is_mult || is_multu) ?
                       CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
              busy  <= 1'b1;
              state <= BUSY;
            end else if (is_mthi) begin
              hi <= a;
            end else if (is_mtlo) begin
              lo <= a;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            hi    <= pend.hi;
            lo    <= pend.lo;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_responder.sv
// Testbench for mdu_responder: directed spec cases plus random ops
// checked against an arithmetic reference model of HI/LO and busy length.
module tb_mdu_responder;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;

  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  mdu_responder #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, returns {hi, lo}.
  function automatic logic [63:0] ref_res(input logic [2:0] o,
      input logic [31:0] x, input logic [31:0] y);
    int sx = x;
    int sy = y;
    longint lx = longint'(sx);
    longint ly = longint'(sy);
    longint unsigned ux = x;
    longint unsigned uy = y;
    longint p;
    longint unsigned up;
    longint q;
    longint r;
    ref_res = '0;
    case (o)
      3'd0: begin p = lx * ly; ref_res = p; end
      3'd1: begin up = ux * uy; ref_res = up; end
      3'd2, 3'd3: begin
        if (y == 0) ref_res = {x, 32'hFFFF_FFFF};
        else if (o == 3'd2) begin
          q = lx / ly;
          r = lx % ly;
          ref_res = {r[31:0], q[31:0]};
        end else begin
          up = ux / uy;
          p = longint'(ux % uy);
          ref_res = {p[31:0], up[31:0]};
        end
      end
      default: ref_res = '0;
    endcase
  endfunction

  function automatic int lat(input logic [2:0] o);
    if (o <= 3'd1) return MC;
    if (o <= 3'd3) return DC;
    return 0;
  endfunction

  // Counts busy-high cycles following the request edge (bounded).
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [31:0] x, input logic [31:0] y);
    logic [63:0] r;
    int n;
    r = ref_res(o, x, y);
    if (o <= 3'd3) begin mhi = r[63:32]; mlo = r[31:0]; end
    else if (o == 3'd4) mhi = x;
    else if (o == 3'd5) mlo = x;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(n);
    chk({tag, "_busy"}, 32'(n), 32'(lat(o)));
    chk({tag, "_hi"}, hi, mhi);
    chk({tag, "_lo"}, lo, mlo);
  endtask

  initial begin
    int n;
    logic [63:0] r1;
    logic [63:0] r2;
    logic [2:0] ro;
    logic [31:0] ra;
    logic [31:0] rb;

    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    run_op("mult", 3'd0, 32'hFFFF_FFFD, 32'd7);
    chk("mult_hi_k", hi, 32'hFFFF_FFFF);
    chk("mult_lo_k", lo, 32'hFFFF_FFEB);
    run_op("multu", 3'd1, 32'hFFFF_FFFD, 32'd7);
    chk("multu_hi_k", hi, 32'h0000_0006);
    run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2);
    chk("div_lo_k", lo, 32'hFFFF_FFFD);
    chk("div_hi_k", hi, 32'hFFFF_FFFF);
    run_op("divu", 3'd3, 32'd7, 32'd2);
    chk("divu_lo_k", lo, 32'd3);
    chk("divu_hi_k", hi, 32'd1);
    run_op("div0", 3'd2, 32'h1234_5678, 32'd0);
    chk("div0_lo_k", lo, 32'hFFFF_FFFF);
    run_op("divov", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("divov_lo_k", lo, 32'h8000_0000);
    chk("divov_hi_k", hi, 32'd0);

    // MTHI while busy on a MULT is dropped.
    r1 = ref_res(3'd0, 32'd11, 32'd13);
    start = 1'b1; op = 3'd0; a = 32'd11; b = 32'd13;
    @(posedge clk); #1;
    op = 3'd4; a = 32'hAAAA_5555;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(n);
    chk("mthi_busy_hi", hi, r1[63:32]);
    chk("mthi_busy_lo", lo, r1[31:0]);
    mhi = r1[63:32]; mlo = r1[31:0];

    run_op("mtlo", 3'd5, 32'd1, 32'd0);
    chk("mtlo_lo_k", lo, 32'd1);
    run_op("nop6", 3'd6, 32'hDEAD_BEEF, 32'd3);

    // Back-to-back: start on the busy-falling edge ignored.
    r1 = ref_res(3'd0, 32'd100, 32'd3);
    r2 = ref_res(3'd1, 32'hFFFF_0000, 32'h0001_0001);
    start = 1'b1; op = 3'd0; a = 32'd100; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (MC - 1) begin @(posedge clk); #1; end
    chk("b2b_still_busy", {31'd0, busy}, 32'd1);
    start = 1'b1; op = 3'd1; a = 32'hFFFF_0000; b = 32'h0001_0001;
    @(posedge clk); #1;
    chk("b2b_fall_busy", {31'd0, busy}, 32'd0);
    chk("b2b_first_lo", lo, r1[31:0]);
    chk("b2b_first_hi", hi, r1[63:32]);
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(n);
    chk("b2b_second_busy", 32'(n), 32'(MC));
    chk("b2b_second_hi", hi, r2[63:32]);
    chk("b2b_second_lo", lo, r2[31:0]);

    // Async reset mid-DIV, no clock edge needed.
    start = 1'b1; op = 3'd2; a = 32'd99; b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    mhi = '0; mlo = '0;
    run_op("post_rst", 3'd1, 32'd6, 32'd9);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
